// File: rtl/lcd_window_ctrl.sv
// Image-window display controller: serial image load, movable WIN x WIN window,
// mirrored scan-out. Define LCD_WIN_MAX_EN to append a window-maximum beat.
module lcd_window_ctrl #(
    parameter int DW    = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int WIN   = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] datain,
    input  logic [2:0]    cmd,
    input  logic          cmd_valid,
    output logic [DW-1:0] dataout,
    output logic          output_valid,
    output logic          output_last,
    output logic          busy
);
    localparam int N    = IMG_W * IMG_H;
    localparam int NB   = WIN * WIN;
`ifdef LCD_WIN_MAX_EN
    localparam int NBT  = NB + 1;
`else
    localparam int NBT  = NB;
`endif
    localparam int DMAX = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    localparam int CW   = $clog2(DMAX + 1);
    localparam int AW   = (N > 1) ? $clog2(N) : 1;
    localparam int BW   = $clog2(NBT + 1);

    localparam logic [CW-1:0] X0    = CW'((IMG_W - WIN + 1) / 2);
    localparam logic [CW-1:0] Y0    = CW'((IMG_H - WIN + 1) / 2);
    localparam logic [CW-1:0] XMAX  = CW'(IMG_W - WIN);
    localparam logic [CW-1:0] YMAX  = CW'(IMG_H - WIN);
    localparam logic [CW-1:0] WLAST = CW'(WIN - 1);
    localparam logic [AW-1:0] ALAST = AW'(N - 1);
    localparam logic [BW-1:0] BTOT  = BW'(NBT);
    localparam logic [BW-1:0] BLAST = BW'(NBT - 1);
    localparam logic [BW-1:0] BPIX  = BW'(NB);

    localparam logic [2:0] C_LOAD = 3'd1, C_SR = 3'd2, C_SL = 3'd3, C_SU = 3'd4,
                           C_SD = 3'd5, C_MX = 3'd6, C_MY = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PRINT} state_t;

    state_t        r_state;
    logic [DW-1:0] r_mem [N];
    logic [AW-1:0] r_cnt;
    logic [BW-1:0] r_beat;
    logic [CW-1:0] r_sr, r_sc, r_ox, r_oy;
    logic          r_mx, r_my, r_busy, r_valid, r_last;
    logic [DW-1:0] r_data;
`ifdef LCD_WIN_MAX_EN
    logic [DW-1:0] r_max;
`endif

    logic          w_acc, w_emit, w_mx, w_my;
    logic [CW-1:0] w_ox, w_oy, w_row, w_col;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_pix;

    // Beat 0 leaves on the accepting edge, so it addresses with the post-command origin/mirrors.
    always_comb begin
        w_acc = cmd_valid & ~r_busy;
        w_ox  = r_ox;
        w_oy  = r_oy;
        w_mx  = r_mx;
        w_my  = r_my;
        if (w_acc) begin
            case (cmd)
                C_LOAD: begin w_ox = X0; w_oy = Y0; w_mx = 1'b0; w_my = 1'b0; end
                C_SR:   if (r_ox != XMAX) w_ox = r_ox + 1'b1;
                C_SL:   if (r_ox != '0)   w_ox = r_ox - 1'b1;
                C_SU:   if (r_oy != '0)   w_oy = r_oy - 1'b1;
                C_SD:   if (r_oy != YMAX) w_oy = r_oy + 1'b1;
                C_MX:   w_mx = ~r_mx;
                C_MY:   w_my = ~r_my;
                default: ;
            endcase
        end
        w_row  = w_my ? (WLAST - r_sr) : r_sr;
        w_col  = w_mx ? (WLAST - r_sc) : r_sc;
        w_addr = AW'((int'(w_oy) + int'(w_row)) * IMG_W + int'(w_ox) + int'(w_col));
        // The first beat after LOAD can coincide with the final pixel write.
        w_pix  = (r_state == S_LOAD && w_addr == r_cnt) ? datain : r_mem[w_addr];
        w_emit = (r_state == S_IDLE  && w_acc && cmd != C_LOAD) ||
                 (r_state == S_LOAD  && r_cnt == ALAST) ||
                 (r_state == S_PRINT && r_beat != BTOT);
    end

    always_ff @(posedge clk) begin
        if (!reset && r_state == S_LOAD)
            r_mem[r_cnt] <= datain;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_ox    <= X0;
            r_oy    <= Y0;
            r_mx    <= 1'b0;
            r_my    <= 1'b0;
            r_cnt   <= '0;
            r_beat  <= '0;
            r_sr    <= '0;
            r_sc    <= '0;
`ifdef LCD_WIN_MAX_EN
            r_max   <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            case (r_state)
                S_IDLE: if (w_acc) begin
                    r_ox    <= w_ox;
                    r_oy    <= w_oy;
                    r_mx    <= w_mx;
                    r_my    <= w_my;
                    r_busy  <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= (cmd == C_LOAD) ? S_LOAD : S_PRINT;
                end
                S_LOAD: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == ALAST) r_state <= S_PRINT;
                end
                S_PRINT: if (r_beat == BTOT) begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_beat  <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_emit) begin
                r_valid <= 1'b1;
                r_last  <= (r_beat == BLAST);
                r_beat  <= r_beat + 1'b1;
                r_data  <= w_pix;
                // Scan counters wrap to 0,0 after the last pixel, ready for the next stream.
                if (r_beat < BPIX) begin
                    if (r_sc == WLAST) begin
                        r_sc <= '0;
                        r_sr <= (r_sr == WLAST) ? '0 : r_sr + 1'b1;
                    end else begin
                        r_sc <= r_sc + 1'b1;
                    end
                end
`ifdef LCD_WIN_MAX_EN
                if (r_beat == BPIX)
                    r_data <= r_max;
                if (r_beat == '0)
                    r_max <= w_pix;
                else if (r_beat < BPIX && w_pix > r_max)
                    r_max <= w_pix;
`endif
            end
        end
    end

    assign dataout      = r_data;
    assign output_valid = r_valid;
    assign output_last  = r_last;
    assign busy         = r_busy;
endmodule

// File: tb/tb_lcd_window_ctrl.sv
// Bench for lcd_window_ctrl: fixed command table, hand-written corner sequences
// and random commands checked against a behavioural window model.
module tb_lcd_window_ctrl;
    localparam int DW = 8, IW = 8, IH = 8, WIN = 3;
    localparam int N = IW * IH, NB = WIN * WIN;
`ifdef LCD_WIN_MAX_EN
    localparam int NBT = NB + 1;
`else
    localparam int NBT = NB;
`endif

    logic          clk = 1'b0;
    logic          reset, cmd_valid;
    logic [DW-1:0] datain;
    logic [2:0]    cmd;
    logic [DW-1:0] dataout;
    logic          output_valid, output_last, busy;

    lcd_window_ctrl #(.DW(DW), .IMG_W(IW), .IMG_H(IH), .WIN(WIN)) dut (
        .clk(clk), .reset(reset), .datain(datain), .cmd(cmd), .cmd_valid(cmd_valid),
        .dataout(dataout), .output_valid(output_valid), .output_last(output_last), .busy(busy));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // stimulus image for the next LOAD, and the model's view of the design state
    int img [N];
    int mdl_mem [N];
    int mox, moy;
    bit mmx, mmy;
    int exp_q [$];

    typedef struct {
        logic [2:0] c;
        int         exp [NB];
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_centre();
        mox = (IW - WIN + 1) / 2;
        moy = (IH - WIN + 1) / 2;
        mmx = 1'b0;
        mmy = 1'b0;
    endtask

    // Applies an accepted command to the model and lists the expected stream.
    task automatic model_cmd(input logic [2:0] c);
        int r, col, v, mx;
        case (c)
            3'd1: begin for (int i = 0; i < N; i++) mdl_mem[i] = img[i]; model_centre(); end
            3'd2: if (mox < IW - WIN) mox++;
            3'd3: if (mox > 0) mox--;
            3'd4: if (moy > 0) moy--;
            3'd5: if (moy < IH - WIN) moy++;
            3'd6: mmx = !mmx;
            3'd7: mmy = !mmy;
            default: ;
        endcase
        exp_q.delete();
        mx = 0;
        for (int k = 0; k < NB; k++) begin
            r   = k / WIN;
            col = k % WIN;
            if (mmy) r = WIN - 1 - r;
            if (mmx) col = WIN - 1 - col;
            v = mdl_mem[(moy + r) * IW + mox + col];
            exp_q.push_back(v);
            if (v > mx) mx = v;
        end
`ifdef LCD_WIN_MAX_EN
        exp_q.push_back(mx);
`endif
    endtask

    // Issues one command and checks the whole busy window against exp_q.
    task automatic run_cmd(input logic [2:0] c, input string name, input bit inject);
        int got_q [$];
        int busy_cyc, first_v, last_pos, n_last, bad_out, t, e;
        busy_cyc = 0; first_v = -1; last_pos = -1; n_last = 0; bad_out = 0; t = 0;
        @(negedge clk);
        cmd = c;
        cmd_valid = 1'b1;
        @(posedge clk);
        forever begin
            @(negedge clk);
            t++;
            cmd_valid = inject && t >= 2 && t <= 5;
            if (inject) cmd = 3'd4;
            datain = (c == 3'd1 && t <= N) ? DW'(img[t-1]) : DW'($urandom);
            if (!busy || t > 400) break;
            busy_cyc++;
            if (output_valid) begin
                if (first_v < 0) first_v = t;
                got_q.push_back(int'(dataout));
                if (output_last) begin n_last++; last_pos = got_q.size(); end
            end else if (dataout != '0 || output_last) begin
                bad_out++;
            end
        end
        cmd_valid = 1'b0;
        chk({name, " busy cycles"}, busy_cyc, (c == 3'd1 ? N : 0) + NBT);
        chk({name, " first beat cycle"}, first_v, (c == 3'd1 ? N : 0) + 1);
        chk({name, " beat count"}, got_q.size(), exp_q.size());
        chk({name, " last count"}, n_last, 1);
        chk({name, " last position"}, last_pos, NBT);
        chk({name, " idle outputs nonzero"}, bad_out, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            e = (i < got_q.size()) ? got_q[i] : -1;
            chk($sformatf("%s beat %0d", name, i), e, exp_q[i]);
        end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd = '0; datain = '0;
        model_centre();
        for (int i = 0; i < N; i++) begin img[i] = i; mdl_mem[i] = 0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset valid", int'(output_valid), 0);
        chk("reset last", int'(output_last), 0);
        chk("reset dataout", int'(dataout), 0);
        reset = 1'b0;

        tbl[0].c = 3'd1; tbl[0].exp = '{27, 28, 29, 35, 36, 37, 43, 44, 45};
        tbl[1].c = 3'd2; tbl[1].exp = '{28, 29, 30, 36, 37, 38, 44, 45, 46};
        tbl[2].c = 3'd2; tbl[2].exp = '{29, 30, 31, 37, 38, 39, 45, 46, 47};
        tbl[3].c = 3'd2; tbl[3].exp = '{29, 30, 31, 37, 38, 39, 45, 46, 47};
        tbl[4].c = 3'd1; tbl[4].exp = '{27, 28, 29, 35, 36, 37, 43, 44, 45};
        tbl[5].c = 3'd6; tbl[5].exp = '{29, 28, 27, 37, 36, 35, 45, 44, 43};
        tbl[6].c = 3'd7; tbl[6].exp = '{45, 44, 43, 37, 36, 35, 29, 28, 27};
        for (int v = 0; v < 7; v++) begin
            int mx;
            model_cmd(tbl[v].c);
            exp_q.delete();
            mx = 0;
            for (int i = 0; i < NB; i++) begin
                exp_q.push_back(tbl[v].exp[i]);
                if (tbl[v].exp[i] > mx) mx = tbl[v].exp[i];
            end
`ifdef LCD_WIN_MAX_EN
            exp_q.push_back(mx);
`endif
            run_cmd(tbl[v].c, $sformatf("vec%0d", v), 1'b0);
        end

        // SHIFT_U strobed during a PRINT must not move the window
        model_cmd(3'd0);
        run_cmd(3'd0, "refresh with ignored shift", 1'b1);
        model_cmd(3'd0);
        run_cmd(3'd0, "refresh after ignored shift", 1'b0);

        // reset during LOAD at pixel 20: pixels 0..19 written, origin/mirrors reset
        model_cmd(3'd2);
        run_cmd(3'd2, "pre-reset shift", 1'b0);
        for (int i = 0; i < N; i++) img[i] = int'($urandom_range(0, 255));
        @(negedge clk);
        cmd = 3'd1;
        cmd_valid = 1'b1;
        @(posedge clk);
        for (int t = 1; t <= 21; t++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            datain = DW'(img[t-1]);
            if (t == 21) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        chk("mid-load reset busy", int'(busy), 0);
        chk("mid-load reset valid", int'(output_valid), 0);
        chk("mid-load reset dataout", int'(dataout), 0);
        for (int i = 0; i < 20; i++) mdl_mem[i] = img[i];
        model_centre();
        model_cmd(3'd0);
        run_cmd(3'd0, "refresh after reset", 1'b0);
        // walk to the top-left corner so the partially written rows are displayed
        for (int i = 0; i < 4; i++) begin
            model_cmd(3'd4);
            run_cmd(3'd4, "shift up to top", 1'b0);
            model_cmd(3'd3);
            run_cmd(3'd3, "shift left to edge", 1'b0);
        end

        for (int n = 0; n < 40; n++) begin
            logic [2:0] c;
            c = 3'($urandom_range(0, 7));
            if (c == 3'd1 && ($urandom % 3) != 0) c = 3'd0;
            if (c == 3'd1)
                for (int i = 0; i < N; i++) img[i] = int'($urandom_range(0, 255));
            model_cmd(c);
            run_cmd(c, $sformatf("rand%0d cmd%0d", n, c), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
